// File: rtl/regfile_seq.sv
// Command sequencer for the RegFile control side: one command in, 1-3 cycles of RegFile control, one response out.
// Optional build macro REGFILE_SEQ_READBACK_EN adds a VERIFY cycle that returns the post-write register value.
module regfile_seq #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [1:0]   cmd_dst,
    input  logic [1:0]   cmd_src,
    input  logic [N-1:0] cmd_imm,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_err,
    output logic [1:0]   rf_funsel,
    output logic [3:0]   rf_regsel,
    output logic [1:0]   rf_outasel,
    output logic [1:0]   rf_outbsel,
    output logic [N-1:0] rf_i,
    input  logic [N-1:0] rf_outa,
    input  logic [N-1:0] rf_outb,
    output logic [7:0]   done_cnt,
    output logic [2:0]   dbg_state
);

    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_DEC  = 3'b010;
    localparam logic [2:0] OP_INC  = 3'b011;
    localparam logic [2:0] OP_READ = 3'b100;
    localparam logic [2:0] OP_MOVE = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
`ifdef REGFILE_SEQ_READBACK_EN
        S_VERIFY = 3'd4,
`endif
        S_RESP  = 3'd5
    } state_t;

    state_t         state;
    logic [2:0]     op_q;
    logic [1:0]     dst_q;
    logic [N-1:0]   data_q;

    assign dbg_state = state;

    // Active-low one-cold write enable for register idx.
    function automatic logic [3:0] sel_of(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // cmd_ready is high only in IDLE; rsp_valid/rsp_data/rsp_err stay frozen until rsp_ready.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            rf_funsel  <= 2'b00;
            rf_regsel  <= 4'b1111;
            rf_outasel <= 2'b00;
            rf_outbsel <= 2'b00;
            rf_i       <= '0;
            done_cnt   <= 8'd0;
            op_q       <= 3'b000;
            dst_q      <= 2'b00;
            data_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    rf_regsel <= 4'b1111;
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        dst_q     <= cmd_dst;
                        cmd_ready <= 1'b0;
                        case (cmd_op)
                            OP_CLR, OP_LDI, OP_DEC, OP_INC: begin
                                state     <= S_EXEC;
                                rf_regsel <= sel_of(cmd_dst);
                                rf_funsel <= cmd_op[1:0];
                                rf_i      <= (cmd_op == OP_LDI) ? cmd_imm : '0;
                            end
                            OP_READ, OP_MOVE: begin
                                state      <= S_READ;
                                rf_outasel <= cmd_src;
                            end
                            default: begin
                                state     <= S_RESP;
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_data  <= '0;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    rf_regsel <= 4'b1111;
`ifdef REGFILE_SEQ_READBACK_EN
                    state      <= S_VERIFY;
                    rf_outbsel <= dst_q;
`else
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= '0;
`endif
                end
                S_READ: begin
                    data_q <= rf_outa;
                    if (op_q == OP_MOVE) begin
                        state     <= S_WRITE;
                        rf_regsel <= sel_of(dst_q);
                        rf_funsel <= 2'b01;
                        rf_i      <= rf_outa;
                    end else begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= rf_outa;
                    end
                end
                S_WRITE: begin
                    rf_regsel <= 4'b1111;
`ifdef REGFILE_SEQ_READBACK_EN
                    state      <= S_VERIFY;
                    rf_outbsel <= dst_q;
`else
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= data_q;
`endif
                end
`ifdef REGFILE_SEQ_READBACK_EN
                S_VERIFY: begin
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= rf_outb;
                end
`endif
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        done_cnt  <= done_cnt + 8'd1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rf_regsel <= 4'b1111;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_seq.sv
// Directed bench for regfile_seq with a behavioural 4x8 RegFile attached to its control outputs.
module tb_regfile_seq;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'b000;
    logic [1:0] cmd_dst = 2'b00;
    logic [1:0] cmd_src = 2'b00;
    logic [7:0] cmd_imm = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [1:0] rf_funsel;
    logic [3:0] rf_regsel;
    logic [1:0] rf_outasel;
    logic [1:0] rf_outbsel;
    logic [7:0] rf_i;
    logic [7:0] rf_outa;
    logic [7:0] rf_outb;
    logic [7:0] done_cnt;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exec_regsel;
    logic [1:0] exec_funsel;
    logic [7:0] exec_i;
    logic       any_write;

    always #5 CLK = ~CLK;

    regfile_seq #(.N(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rf_funsel(rf_funsel), .rf_regsel(rf_regsel), .rf_outasel(rf_outasel),
        .rf_outbsel(rf_outbsel), .rf_i(rf_i), .rf_outa(rf_outa), .rf_outb(rf_outb),
        .done_cnt(done_cnt), .dbg_state(dbg_state)
    );

    // Behavioural RegFile: active-low per-register enables, FunSel 00 clr/01 load/10 dec/11 inc.
    logic [7:0] rf_mem [0:3] = '{default: 8'h00};
    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (!rf_regsel[i]) begin
                case (rf_funsel)
                    2'b00: rf_mem[i] <= 8'h00;
                    2'b01: rf_mem[i] <= rf_i;
                    2'b10: rf_mem[i] <= rf_mem[i] - 8'd1;
                    default: rf_mem[i] <= rf_mem[i] + 8'd1;
                endcase
            end
        end
    end
    assign rf_outa = rf_mem[rf_outasel];
    assign rf_outb = rf_mem[rf_outbsel];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command, measure latency, check the response, then handshake it.
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [1:0] dst,
                          input logic [1:0] src, input logic [7:0] imm,
                          input logic [7:0] exp_plain, input logic [7:0] exp_rb,
                          input logic exp_err, input int exp_lat, input logic is_write,
                          input int hold);
        int lat;
        logic [7:0] exp_data;
        logic [7:0] cnt_before;
        lat = 0;
        exp_data = exp_plain;
`ifdef REGFILE_SEQ_READBACK_EN
        if (is_write) begin
            exp_data = exp_rb;
            exp_lat  = exp_lat + 1;
        end
`else
        if (is_write && exp_rb !== exp_plain && 1'b0) exp_data = exp_rb;
`endif
        @(negedge CLK);
        check({tag, " cmd_ready"}, cmd_ready, 1);
        cnt_before = done_cnt;
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        any_write = 1'b0;
        while (lat < 10) begin
            @(negedge CLK);
            lat++;
            if (lat == 1) begin
                exec_regsel = rf_regsel;
                exec_funsel = rf_funsel;
                exec_i      = rf_i;
            end
            if (rf_regsel != 4'b1111) any_write = 1'b1;
            check({tag, " regsel one-cold"}, ($countones(rf_regsel) >= 3), 1);
            if (rsp_valid) break;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rsp_data"}, rsp_data, exp_data);
        check({tag, " rsp_err"}, rsp_err, exp_err);
        for (int k = 0; k < hold; k++) begin
            @(negedge CLK);
            check({tag, " hold rsp_valid"}, rsp_valid, 1);
            check({tag, " hold rsp_data"}, rsp_data, exp_data);
            check({tag, " hold cmd_ready"}, cmd_ready, 0);
            check({tag, " hold done_cnt"}, done_cnt, cnt_before);
        end
        rsp_ready = 1'b1;
        @(posedge CLK);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        // Reset values while RST_N is low.
        #12;
        check("reset regsel", rf_regsel, 4'b1111);
        check("reset funsel", rf_funsel, 2'b00);
        check("reset rf_i", rf_i, 8'h00);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset done_cnt", done_cnt, 0);
        check("reset cmd_ready", cmd_ready, 1);
        RST_N = 1'b1;

        do_cmd("ldi r2", 3'b001, 2'd2, 2'd0, 8'hAA, 8'h00, 8'hAA, 0, 2, 1, 0);
        check("ldi exec regsel", exec_regsel, 4'b1011);
        check("ldi exec funsel", exec_funsel, 2'b01);
        check("ldi exec rf_i", exec_i, 8'hAA);
        do_cmd("read r2", 3'b100, 2'd0, 2'd2, 8'h00, 8'hAA, 8'hAA, 0, 2, 0, 0);

        do_cmd("ldi r1", 3'b001, 2'd1, 2'd0, 8'hFF, 8'h00, 8'hFF, 0, 2, 1, 0);
        do_cmd("inc r1", 3'b011, 2'd1, 2'd0, 8'h00, 8'h00, 8'h00, 0, 2, 1, 0);
        check("inc exec funsel", exec_funsel, 2'b11);
        do_cmd("read r1 wrap", 3'b100, 2'd0, 2'd1, 8'h00, 8'h00, 8'h00, 0, 2, 0, 0);
        do_cmd("dec r1", 3'b010, 2'd1, 2'd0, 8'h00, 8'h00, 8'hFF, 0, 2, 1, 0);
        check("dec exec funsel", exec_funsel, 2'b10);
        do_cmd("read r1 dec", 3'b100, 2'd0, 2'd1, 8'h00, 8'hFF, 8'hFF, 0, 2, 0, 0);

        do_cmd("ldi r0", 3'b001, 2'd0, 2'd0, 8'h3C, 8'h00, 8'h3C, 0, 2, 1, 0);
        do_cmd("move r0->r3", 3'b101, 2'd3, 2'd0, 8'h00, 8'h3C, 8'h3C, 0, 3, 1, 0);
        do_cmd("read r3", 3'b100, 2'd0, 2'd3, 8'h00, 8'h3C, 8'h3C, 0, 2, 0, 0);

        do_cmd("illegal 110", 3'b110, 2'd1, 2'd0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0);
        check("illegal no write", any_write, 0);
        do_cmd("clr r3", 3'b000, 2'd3, 2'd0, 8'h55, 8'h00, 8'h00, 0, 2, 1, 0);
        check("clr exec regsel", exec_regsel, 4'b0111);
        check("clr exec rf_i", exec_i, 8'h00);
        check("done_cnt after 12", done_cnt, 8'd12);

        do_cmd("stall read r2", 3'b100, 2'd0, 2'd2, 8'h00, 8'hAA, 8'hAA, 0, 2, 0, 5);
        check("done_cnt after stall", done_cnt, 8'd13);

        do_cmd("move r2->r2", 3'b101, 2'd2, 2'd2, 8'h00, 8'hAA, 8'hAA, 0, 3, 1, 0);
        do_cmd("read r2 self", 3'b100, 2'd0, 2'd2, 8'h00, 8'hAA, 8'hAA, 0, 2, 0, 0);
        check("done_cnt after 15", done_cnt, 8'd15);

        // Abort an LDI to R0 by asserting reset during its EXEC cycle.
        @(negedge CLK);
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_dst = 2'd0; cmd_imm = 8'h55;
        @(posedge CLK);
        #1 cmd_valid = 1'b0;
        @(negedge CLK);
        check("abort exec regsel", rf_regsel, 4'b1110);
        RST_N = 1'b0;
        #1;
        check("abort regsel", rf_regsel, 4'b1111);
        check("abort rsp_valid", rsp_valid, 0);
        @(posedge CLK);
        #3 RST_N = 1'b1;
        @(negedge CLK);
        check("post-reset cmd_ready", cmd_ready, 1);
        check("post-reset done_cnt", done_cnt, 8'd0);
        check("post-reset state", dbg_state, 3'd0);
        do_cmd("read r0 kept", 3'b100, 2'd0, 2'd0, 8'h00, 8'h3C, 8'h3C, 0, 2, 0, 0);
        check("done_cnt after reset", done_cnt, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
